// File: rtl/seq_mult_8x8.sv
// Sequential unsigned shift-and-add multiplier (8x8 -> 16) built around a
// 16-bit ripple-carry adder. One multiply takes 8 RUN cycles plus one DONE
// cycle; start is only honoured while idle.

module RCA_16_bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] s,
    output logic        c_out
);
    logic [16:0] c;

    assign c[0] = c_in;

    genvar i;
    generate
        for (i = 0; i < 16; i++) begin : g_fa
            assign s[i]   = a[i] ^ b[i] ^ c[i];
            assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign c_out = c[16];
endmodule

module seq_mult_8x8 #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               done
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [1:0]         state_q,  state_d;
    logic [2*WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q,    acc_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;

    logic [2*WIDTH-1:0] addend;
    logic [2*WIDTH-1:0] sum;
    logic               carry_unused;

    // Partial product: add the shifted multiplicand only when the current
    // multiplier LSB is set. The carry out can never be set (255*255 < 2^16).
    assign addend = mplier_q[0] ? mcand_q : '0;

    RCA_16_bit u_rca (
        .a     (acc_q),
        .b     (addend),
        .c_in  (1'b0),
        .s     (sum),
        .c_out (carry_unused)
    );

    // Next-state and datapath update for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    mcand_d  = {{WIDTH{1'b0}}, a};
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                // Always run all WIDTH iterations, even once the multiplier is
                // exhausted, so latency is data independent.
                acc_d    = sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign product = acc_q;
    assign busy    = busy_q;
    assign done    = done_q;
endmodule

// File: tb/tb_seq_mult_8x8.sv
// Self-checking bench for seq_mult_8x8: directed table, multi-cycle corner
// sequences and a randomized sweep against a plain a*b reference.

module tb_seq_mult_8x8;
    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] product;
    logic        busy;
    logic        done;

    int nvec = 0;
    int nerr = 0;

    seq_mult_8x8 dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .product (product),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Done must only appear while busy and never for two cycles in a row.
    logic done_prev = 1'b0;
    always @(posedge clk) begin
        #2;
        if (done) begin
            chk("done_implies_busy", int'(busy), 1);
            chk("done_single_cycle", int'(done_prev), 0);
        end
        done_prev = done;
    end

    // Issue one multiply and observe 10 sampled cycles after the accept edge.
    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib,
                          output int lat, output int ndone, output int nbusy,
                          output logic [15:0] p_done, output logic [15:0] p_after);
        lat = -1; ndone = 0; nbusy = 0; p_done = 'x; p_after = 'x;
        a = ia; b = ib; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                lat = i;
                p_done = product;
            end
            if (i == 9) p_after = product;
        end
    endtask

    initial begin
        vec_t tbl[4];
        int lat, ndone, nbusy;
        logic [15:0] pd, pa;
        int dcount, last_edge;

        tbl[0] = '{8'h0F, 8'h0F, 16'h00E1};
        tbl[1] = '{8'hFF, 8'hFF, 16'hFE01};
        tbl[2] = '{8'h00, 8'hAB, 16'h0000};
        tbl[3] = '{8'h01, 8'h80, 16'h0080};

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_product", int'(product), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table: result, latency, busy length, done width, hold.
        for (int i = 0; i < 4; i++) begin
            run_op(tbl[i].a, tbl[i].b, lat, ndone, nbusy, pd, pa);
            chk($sformatf("tbl%0d_product", i), int'(pd), int'(tbl[i].exp));
            chk($sformatf("tbl%0d_latency", i), lat, 8);
            chk($sformatf("tbl%0d_done_count", i), ndone, 1);
            chk($sformatf("tbl%0d_busy_cycles", i), nbusy, 9);
            chk($sformatf("tbl%0d_hold", i), int'(pa), int'(tbl[i].exp));
        end

        // Start while busy must be ignored.
        a = 8'h12; b = 8'h34; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dcount = 0; pd = '0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (done) begin
                dcount++;
                pd = product;
            end
        end
        chk("busy_start_done_count", dcount, 1);
        chk("busy_start_product", int'(pd), 16'h03A8);
        chk("busy_start_idle", int'(busy), 0);
        chk("busy_start_hold", int'(product), 16'h03A8);

        // Reset in the middle of RUN aborts with no done pulse.
        a = 8'hC3; b = 8'h5A; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_product", int'(product), 0);
        dcount = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        chk("abort_no_done", dcount, 0);
        chk("abort_product_stays", int'(product), 0);

        // Back-to-back with start held high.
        a = 8'h03; b = 8'h05; start = 1'b1;
        dcount = 0; last_edge = -1;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk); #1;
            if (done) begin
                chk("b2b_product", int'(product), 16'h000F);
                if (last_edge >= 0) chk("b2b_period", i - last_edge, 10);
                last_edge = i;
                dcount++;
                @(posedge clk); #1;
                i++;
                chk("b2b_idle_hold", int'(product), 16'h000F);
            end
        end
        chk("b2b_pulses", int'(dcount >= 4), 1);
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;

        // Randomized sweep against the arithmetic reference.
        for (int n = 0; n < 1000; n++) begin
            logic [7:0] ra, rb;
            int exp;
            ra = 8'($urandom);
            rb = 8'($urandom);
            exp = int'(ra) * int'(rb);
            run_op(ra, rb, lat, ndone, nbusy, pd, pa);
            chk($sformatf("rand_%0h_x_%0h", ra, rb), int'(pd), exp);
            chk("rand_latency", lat, 8);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
